// File: rtl/shifter_pkg.sv
// Shared types for the pipelined ARM operand shifter.
// It holds the request mode encoding, the barrel shift types, the special-case
// classes that stage 1 resolves ahead of the shift, and the default datapath width.
package shifter_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [2:0] {
    MODE_IMM_ROT   = 3'b000,
    MODE_SHIFT_IMM = 3'b001,
    MODE_SHIFT_REG = 3'b010,
    MODE_LS_IMM    = 3'b011,
    MODE_LS_REG    = 3'b100,
    MODE_LS_SCALED = 3'b101
  } mode_e;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } sh_type_e;

  // CL_NORM : shift by 0 < amt < WIDTH
  // CL_ZERO : pass rm, carry is the incoming C
  // CL_EQW  : shift of exactly WIDTH (for ROR: a nonzero multiple of WIDTH)
  // CL_GTW  : shift beyond WIDTH
  // CL_RRX  : rotate right by one through carry
  typedef enum logic [2:0] {
    CL_NORM = 3'd0,
    CL_ZERO = 3'd1,
    CL_EQW  = 3'd2,
    CL_GTW  = 3'd3,
    CL_RRX  = 3'd4
  } sh_class_e;

endpackage

// File: rtl/shift_core.sv
// Combinational barrel shifter with ARM carry-out semantics.
// Stage 1 has already reduced the shift to a type, an amount below WIDTH
// and a special-case class, so this block only applies them.
// Ports: rm/c_in  value to shift and incoming C flag
//        typ/amt/cls  decoded shift
//        operand/carry  shifted value and shifter carry-out
module shift_core
  import shifter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] rm,
  input  logic             c_in,
  input  sh_type_e         typ,
  input  logic [SHW-1:0]   amt,
  input  sh_class_e        cls,
  output logic [WIDTH-1:0] operand,
  output logic             carry
);

  logic [SHW-1:0]   amt_m1;
  logic [SHW-1:0]   amt_neg;
  logic [WIDTH-1:0] fill;

  // amt is nonzero for CL_NORM, so amt_neg is WIDTH-amt and amt_m1 is amt-1
  assign amt_m1  = amt - SHW'(1);
  assign amt_neg = SHW'(0) - amt;
  assign fill    = {WIDTH{rm[WIDTH-1]}};

  always_comb begin
    operand = rm;
    carry   = c_in;
    case (cls)
      CL_NORM: begin
        case (typ)
          SH_LSL: begin operand = rm << amt;                     carry = rm[amt_neg]; end
          SH_LSR: begin operand = rm >> amt;                     carry = rm[amt_m1];  end
          SH_ASR: begin operand = $signed(rm) >>> amt;           carry = rm[amt_m1];  end
          SH_ROR: begin operand = (rm >> amt) | (rm << amt_neg); carry = rm[amt_m1];  end
        endcase
      end
      CL_EQW: begin
        case (typ)
          SH_LSL: begin operand = '0;   carry = rm[0];       end
          SH_LSR: begin operand = '0;   carry = rm[WIDTH-1]; end
          SH_ASR: begin operand = fill; carry = rm[WIDTH-1]; end
          SH_ROR: begin operand = rm;   carry = rm[WIDTH-1]; end
        endcase
      end
      CL_GTW: begin
        if (typ == SH_ASR) begin
          operand = fill;
          carry   = rm[WIDTH-1];
        end else begin
          operand = '0;
          carry   = 1'b0;
        end
      end
      CL_RRX: begin
        operand = {c_in, rm[WIDTH-1:1]};
        carry   = rm[0];
      end
      default: begin
        operand = rm;
        carry   = c_in;
      end
    endcase
  end

endmodule

// File: rtl/operand_shifter_pipe.sv
// Two-stage pipelined ARM operand shifter (addressing modes 1 and 2) with a
// valid/ready handshake. Stage 1 decodes the request into a shift type,
// amount and special-case class; stage 2 runs shift_core and registers the result.
// Optional feature macro: SHIFTER_REG_SHIFT_EN enables register-specified
// shifts (mode 010); without it mode 010 reports out_err and in_rs is ignored.
// Ports: clk/reset (synchronous, active high)
//        in_*  request: mode, L field, Rm, Rs[7:0], C flag, tag; in_valid/in_ready
//        out_* result: operand, carry, reserved-mode error, tag; out_valid/out_ready
module operand_shifter_pipe
  import shifter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_mode,
  input  logic [11:0]      in_l,
  input  logic [WIDTH-1:0] in_rm,
  input  logic [7:0]       in_rs,
  input  logic             in_c,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry,
  output logic             out_err,
  output logic [TAG_W-1:0] out_tag
);

  localparam int           SHW = $clog2(WIDTH);
  localparam logic [7:0]   W8  = 8'(WIDTH);

  typedef struct packed {
    sh_class_e      cls;
    logic [SHW-1:0] amt;
  } cl_t;

  typedef struct packed {
    logic [WIDTH-1:0] rm;
    logic             c;
    sh_type_e         typ;
    logic [SHW-1:0]   amt;
    sh_class_e        cls;
    logic             keep_c;  // scaled offsets never update carry
    logic             err;
    logic [TAG_W-1:0] tag;
  } s1_t;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             carry;
    logic             err;
    logic [TAG_W-1:0] tag;
  } s2_t;

  logic [2:1]       vld_pipe_q, vld_pipe_d;
  s1_t              s1_q, s1_d, dec;
  s2_t              s2_q, s2_d;
  cl_t              cl;
  logic             s2_hold, acc, adv;
  logic [WIDTH-1:0] core_op;
  logic             core_c;
  logic             unused_rs;

  assign unused_rs = ^in_rs;

  // Register-style amount resolution: n==0 passes, ROR only looks at n mod WIDTH.
  function automatic cl_t classify(input sh_type_e t, input logic [7:0] n);
    cl_t r;
    r.amt = n[SHW-1:0];
    r.cls = CL_NORM;
    if (n == 8'd0) r.cls = CL_ZERO;
    else begin
      case (t)
        SH_ROR:  if (n[SHW-1:0] == '0) r.cls = CL_EQW;
        SH_ASR:  if (n >= W8) r.cls = CL_EQW;
        default: begin
          if (n == W8)     r.cls = CL_EQW;
          else if (n > W8) r.cls = CL_GTW;
        end
      endcase
    end
    return r;
  endfunction

  assign s2_hold  = vld_pipe_q[2] && !out_ready;
  assign in_ready = !vld_pipe_q[1] || !s2_hold;
  assign acc      = in_valid && in_ready;
  assign adv      = vld_pipe_q[1] && !s2_hold;

  always_comb begin
    dec     = '0;
    cl      = '0;
    dec.rm  = in_rm;
    dec.c   = in_c;
    dec.tag = in_tag;
    dec.typ = sh_type_e'(in_l[6:5]);
    dec.cls = CL_ZERO;
    case (in_mode)
      MODE_IMM_ROT: begin
        // rotate of the 8-bit immediate; carry rule matches ROR of that value
        dec.rm  = WIDTH'(in_l[7:0]);
        dec.typ = SH_ROR;
        cl      = classify(SH_ROR, {3'b000, in_l[11:8], 1'b0});
        dec.cls = cl.cls;
        dec.amt = cl.amt;
      end
      MODE_SHIFT_IMM, MODE_LS_SCALED: begin
        dec.keep_c = (in_mode == MODE_LS_SCALED);
        if (in_l[11:7] == 5'd0) begin
          case (dec.typ)
            SH_LSL:  dec.cls = CL_ZERO;
            SH_ROR:  dec.cls = CL_RRX;
            default: dec.cls = CL_EQW;  // LSR/ASR #0 encode a shift of WIDTH
          endcase
        end else begin
          cl      = classify(dec.typ, {3'b000, in_l[11:7]});
          dec.cls = cl.cls;
          dec.amt = cl.amt;
        end
      end
`ifdef SHIFTER_REG_SHIFT_EN
      MODE_SHIFT_REG: begin
        cl      = classify(dec.typ, in_rs);
        dec.cls = cl.cls;
        dec.amt = cl.amt;
      end
`endif
      MODE_LS_IMM: dec.rm = WIDTH'(in_l);
      MODE_LS_REG: ;
      default: begin
        dec.rm  = '0;
        dec.err = 1'b1;
      end
    endcase
  end

  shift_core #(.WIDTH(WIDTH), .SHW(SHW)) u_core (
    .rm      (s1_q.rm),
    .c_in    (s1_q.c),
    .typ     (s1_q.typ),
    .amt     (s1_q.amt),
    .cls     (s1_q.cls),
    .operand (core_op),
    .carry   (core_c)
  );

  always_comb begin
    vld_pipe_d[1] = in_ready ? in_valid : vld_pipe_q[1];
    vld_pipe_d[2] = s2_hold | vld_pipe_q[1];
    s1_d          = acc ? dec : s1_q;
    s2_d          = s2_q;
    if (adv) begin
      s2_d.data  = core_op;
      s2_d.carry = s1_q.keep_c ? s1_q.c : core_c;
      s2_d.err   = s1_q.err;
      s2_d.tag   = s1_q.tag;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe_q <= '0;
      s1_q       <= '0;
      s2_q       <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
    end
  end

  assign out_valid = vld_pipe_q[2];
  assign out_data  = s2_q.data;
  assign out_carry = s2_q.carry;
  assign out_err   = s2_q.err;
  assign out_tag   = s2_q.tag;

endmodule

// File: doc/operand_shifter_pipe.md
# operand_shifter_pipe

Parametrised, two-stage pipelined successor to the combinational ARM operand shifter. It computes the shifter operand and shifter carry-out for data-processing addressing mode 1, and the offset for load/store addressing mode 2. New capabilities are register-specified shift amounts, scaled register offsets, correct ARM carry semantics for every corner case, and a valid/ready handshake. It sits between the register-file read stage and the ALU in the execute pipeline.

## Interface
- WIDTH, 32, datapath width; power of two, 16..64; SHW = $clog2(WIDTH)
- TAG_W, 4, width of the sideband tag carried alongside each operation
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  request valid
- in_ready  output  1  request accepted when in_valid && in_ready
- in_mode  input  3  000 imm-rotate, 001 shift-imm, 010 shift-reg, 011 ls-imm, 100 ls-reg, 101 ls-scaled; 110/111 reserved
- in_l  input  12  instruction field L[11:0]
- in_rm  input  WIDTH  Rm value
- in_rs  input  8  Rs[7:0], the register shift amount
- in_c  input  1  current CPSR C flag
- in_tag  input  TAG_W  sideband, returned unchanged
- out_valid  output  1  result valid
- out_ready  input  1  result consumed when out_valid && out_ready
- out_data  output  WIDTH  shifter operand / offset
- out_carry  output  1  shifter_carry_out
- out_err  output  1  reserved mode flagged
- out_tag  output  TAG_W  tag of this result

## Operation
- Shift type field: t = L[6:5] (00 LSL, 01 LSR, 10 ASR, 11 ROR). Immediate amount: n = L[11:7].
- imm-rotate: operand = zero-extended L[7:0] rotated right by 2*L[11:8]. Carry = in_c if L[11:8]==0, else operand[WIDTH-1].
- shift-imm:
  - LSL #0: rm, carry in_c.
  - LSR #0 / ASR #0 mean a shift of WIDTH. LSR gives 0; ASR gives sign-fill. Carry = rm[WIDTH-1] in both cases.
  - ROR #0 is RRX: {in_c, rm[WIDTH-1:1]}, carry rm[0].
  - Otherwise: carry is the last bit shifted out (LSL rm[WIDTH-n]; others rm[n-1]).
- shift-reg: n = in_rs[7:0].
  - n==0: rm, carry in_c.
  - LSL/LSR, 0<n<WIDTH: normal shift, last bit out.
  - LSL/LSR, n==WIDTH: 0; carry rm[0] for LSL, rm[WIDTH-1] for LSR.
  - LSL/LSR, n>WIDTH: 0, carry 0.
  - ASR, n>=WIDTH: sign-fill, carry rm[WIDTH-1].
  - ROR: uses n[SHW-1:0]. If that is 0 (with n!=0): rm, carry rm[WIDTH-1]. Otherwise rotate, carry rm[n[SHW-1:0]-1].
- ls-imm: zero-extended L[11:0], carry in_c.
- ls-reg: rm, carry in_c.
- ls-scaled: same operand as shift-imm, carry = in_c.
- Reserved modes: out_data 0, out_carry in_c, out_err 1.
- Stage 1 registers the decode: effective amount, type, the special-case class (zero / eq-WIDTH / gt-WIDTH / RRX), rm, in_c and tag. Stage 2 computes the shift and carry and registers the result.

## Timing
- Latency is 2 cycles from the accept edge to out_valid. Throughput is 1 op/cycle while out_ready stays high.
- Stall: stage 2 holds when out_valid && !out_ready. Stage 1 holds when stage 2 holds and stage 1 is valid. in_ready = !s1_valid || !s2_hold (combinational).
- While out_valid && !out_ready, all out_* signals stay stable.
- Full pipeline with out_ready=1 and in_valid=1: accept, advance and emit all occur in the same cycle; no bubble.
- Reset: s1_valid=0, out_valid=0, out_data=0, out_carry=0, out_err=0, out_tag=0. in_ready reads 1 in the cycle after reset.
- Reset asserted mid-operation discards all in-flight operations; nothing is emitted for them.
- Inputs are sampled only on the accept edge.

## Configuration
- SHIFTER_REG_SHIFT_EN defined: mode 010 behaves as described above.
- SHIFTER_REG_SHIFT_EN undefined:
  - Mode 010 is treated as reserved: out_data 0, carry in_c, out_err 1.
  - The in_rs port remains but is ignored.
  - The stage-1 amount mux and the >=WIDTH comparators are removed.

## Structure
- shifter_pkg holds:
  - the mode enum (MODE_IMM_ROT..MODE_LS_SCALED);
  - the shift type enum (SH_LSL, SH_LSR, SH_ASR, SH_ROR);
  - the special-case class enum;
  - the default WIDTH constant.
- Sub-module shift_core is combinational. It takes rm, in_c, type, amount and class, and returns {operand, carry}. It is instantiated once, in stage 2.

## Test plan
- imm-rotate, L=12'h4FF: 32'hFF000000, carry 1. L=12'h0AB with in_c=0: 32'hAB, carry 0.
- shift-imm, rm=32'h80000001: LSR #0 gives 0, carry 1. ASR #0 gives FFFFFFFF, carry 1. RRX with in_c=1 gives 32'hC0000000, carry 1.
- shift-reg, rm=32'h80000001, LSL: rs=32 gives 0, carry 1. rs=33 gives 0, carry 0. ROR rs=64 gives rm, carry 1.
- Back-to-back 8 ops with out_ready=1: 8 results in order, tags 0..7, first result 2 cycles after the first accept.
- Stalls: out_ready low for 3 cycles with the pipe full. in_ready=0, outputs held stable, no loss or duplication after release.
- Reset asserted with 2 ops in flight: out_valid=0 the next cycle and no stale result appears. Mode 111: out_err=1, out_data=0.
